// File: rtl/vmsu_wb_sequencer.sv
// Wishbone slave that queues multiply commands and sequences the VMSU 8-bit multiplier,
// capturing each product into a readable result register with sticky status and an interrupt.
module vmsu_wb_sequencer #(
  parameter logic [31:0] BASE_ADDR  = 32'h3000_0100,
  parameter int          LATENCY    = 2,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic [7:0]  mul_a,
  output logic [7:0]  mul_b,
  output logic        mul_control,
  input  logic [15:0] mul_p,
  output logic        busy_o,
  output logic        irq_o
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_CAPTURE} state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic        r_ack;
  logic [31:0] r_dat;
  logic [16:0] r_fifo [FIFO_DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_fcnt;
  logic [3:0]  r_cnt;
  logic [7:0]  r_a;
  logic [7:0]  r_b;
  logic        r_ctl;
  logic [15:0] r_result;
  logic [15:0] r_opcnt;
  logic        r_res_valid;
  logic        r_ovf;
  logic        r_lost;
  logic        r_irq_en;

  logic        w_access;
  logic [1:0]  w_off;
  logic        w_wr_ctrl;
  logic        w_clr;
  logic        w_push_req;
  logic        w_push;
  logic        w_load;
  logic        w_capture;
  logic        w_full;
  logic        w_empty;
  logic        w_rd_result;
  logic        w_wr_count;
  logic [31:0] w_status;
  logic [31:0] w_rdata;
  logic        w_unused;

  assign w_access    = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:4] == BASE_ADDR[31:4]) & ~r_ack;
  assign w_off       = wbs_adr_i[3:2];
  assign w_wr_ctrl   = w_access & wbs_we_i & (w_off == 2'd0);
  assign w_clr       = w_wr_ctrl & wbs_dat_i[0];
  assign w_push_req  = w_access & wbs_we_i & (w_off == 2'd1);
  assign w_rd_result = w_access & ~wbs_we_i & (w_off == 2'd2);
  assign w_wr_count  = w_access & wbs_we_i & (w_off == 2'd3);
  assign w_full      = (r_fcnt == CW'(FIFO_DEPTH));
  assign w_empty     = (r_fcnt == '0);
  // Fullness is judged before this edge's pop, so a push into a full FIFO drops even if a slot frees now.
  assign w_push      = w_push_req & ~w_full & ~w_clr;
  assign w_unused    = ^{wbs_sel_i, wbs_adr_i[1:0], wbs_dat_i[31:17]};

  // Sequencer state register
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_load      = 1'b1;
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (r_cnt == 4'd1) w_state_nxt = S_CAPTURE;
      end
      S_CAPTURE: begin
        w_capture   = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_clr) begin
      w_load      = 1'b0;
      w_capture   = 1'b0;
      w_state_nxt = S_IDLE;
    end
  end

  // Command FIFO control
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_fcnt <= '0;
    end else if (w_clr) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_fcnt <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_load) r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_load})
        2'b10:   r_fcnt <= r_fcnt + 1'b1;
        2'b01:   r_fcnt <= r_fcnt - 1'b1;
        default: r_fcnt <= r_fcnt;
      endcase
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (w_push) r_fifo[r_wptr] <= {wbs_dat_i[16], wbs_dat_i[15:8], wbs_dat_i[7:0]};
  end

  // Operand drive and latency counter
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n) begin
      r_a   <= '0;
      r_b   <= '0;
      r_ctl <= 1'b0;
      r_cnt <= '0;
    end else if (w_load) begin
      {r_ctl, r_b, r_a} <= r_fifo[r_rptr];
      r_cnt             <= 4'(LATENCY);
    end else if (r_state == S_WAIT && !w_clr) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  // Result capture and sticky status
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n) begin
      r_result    <= '0;
      r_res_valid <= 1'b0;
      r_ovf       <= 1'b0;
      r_lost      <= 1'b0;
    end else if (w_clr) begin
      r_res_valid <= 1'b0;
      r_ovf       <= 1'b0;
      r_lost      <= 1'b0;
    end else begin
      if (w_push_req && w_full) r_ovf <= 1'b1;
      if (w_capture) begin
        r_result    <= mul_p;
        r_res_valid <= 1'b1;
        if (r_res_valid && !w_rd_result) r_lost <= 1'b1;
      end else if (w_rd_result) begin
        r_res_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n) begin
      r_opcnt  <= '0;
      r_irq_en <= 1'b0;
    end else begin
      if (w_wr_count) begin
        r_opcnt <= '0;
      end else if (w_capture) begin
        r_opcnt <= r_opcnt + 16'd1;
      end
      if (w_wr_ctrl && wbs_dat_i[1]) r_irq_en <= 1'b1;
    end
  end

  always_comb begin
    w_status       = '0;
    w_status[0]    = busy_o;
    w_status[1]    = r_res_valid;
    w_status[2]    = w_full;
    w_status[3]    = w_empty;
    w_status[4]    = r_ovf;
    w_status[5]    = r_lost;
    w_status[12:8] = 5'(r_fcnt);
    w_status[16]   = r_irq_en;
  end

  always_comb begin
    w_rdata = '0;
    case (w_off)
      2'd0:    w_rdata = w_status;
      2'd2:    w_rdata = {15'd0, r_res_valid, r_result};
      2'd3:    w_rdata = {16'd0, r_opcnt};
      default: w_rdata = '0;
    endcase
  end

  // Bus response
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n) begin
      r_ack <= 1'b0;
      r_dat <= '0;
    end else begin
      r_ack <= w_access;
      r_dat <= (w_access && !wbs_we_i) ? w_rdata : 32'd0;
    end
  end

  assign wbs_ack_o   = r_ack;
  assign wbs_dat_o   = r_dat;
  assign mul_a       = r_a;
  assign mul_b       = r_b;
  assign mul_control = r_ctl;
  assign busy_o      = (r_state != S_IDLE) | ~w_empty;
  assign irq_o       = r_res_valid & r_irq_en;

endmodule

// File: doc/vmsu_wb_sequencer.md
Name: vmsu_wb_sequencer

Overview:
- Wishbone slave that queues multiply commands from the management SoC and sequences the 8-bit VMSU multiplier datapath.
- Drives the a/b/control operands, waits the multiplier latency, then captures the 16-bit product into a readable result register with status, sticky error flags and an interrupt.
- Sits in user_project_wrapper between the Wishbone slave port and vmsu_8bit_top, replacing the LA-bit operand drive.

Parameters:
- BASE_ADDR, 32'h3000_0100, window base; decode is on wbs_adr_i[31:4]
- LATENCY, 2, multiplier cycles needed after operands change (1..15)
- FIFO_DEPTH, 4, command FIFO entries (power of 2, 2..16)

Ports:
- wb_clk_i in 1: single clock.
- wb_rst_n in 1: synchronous, active-low reset.
- wbs_cyc_i in 1: Wishbone cycle.
- wbs_stb_i in 1: Wishbone strobe.
- wbs_we_i in 1: write enable.
- wbs_sel_i in 4: byte selects, ignored.
- wbs_adr_i in 32: address.
- wbs_dat_i in 32: write data.
- wbs_ack_o out 1: registered acknowledge.
- wbs_dat_o out 32: read data, valid while ack is high, 0 otherwise.
- mul_a out 8: multiplier operand A.
- mul_b out 8: multiplier operand B.
- mul_control out 1: multiplier mode bit.
- mul_p in 16: multiplier product.
- busy_o out 1: FSM not in IDLE, or FIFO non-empty.
- irq_o out 1: res_valid & irq_en.

Behaviour:
- Reset (wb_rst_n low at an edge): all outputs 0; FSM IDLE; FIFO empty; res_valid, ovf_err, res_lost, irq_en, op_count all 0.
- Bus decode: access = cyc & stb & (adr[31:4]==BASE_ADDR[31:4]) & !ack.
- ack is asserted in the cycle after the access and held for exactly 1 cycle. Held stb therefore gives at most one ack every 2 cycles.
- Non-matching addresses are never acked. Register side effects take place at the same edge that registers ack.
- Offset 0x0 CTRL/STATUS:
  - Write bit0=1: soft clear. Flushes FIFO, clears res_valid/ovf_err/res_lost, aborts the FSM to IDLE with no capture; mul_* hold their values.
  - Write bit1: sets irq_en.
  - Read: [0] busy, [1] res_valid, [2] fifo_full, [3] fifo_empty, [4] ovf_err, [5] res_lost, [12:8] fifo count, [16] irq_en.
- Offset 0x4 CMD:
  - Write pushes {control=dat[16], b=dat[15:8], a=dat[7:0]}.
  - Push while full: dropped, ovf_err sticky set. This applies even when a pop happens at the same edge.
  - Read returns 0.
- Offset 0x8 RESULT: read returns [15:0] product, [16] res_valid; the read clears res_valid. Writes are ignored.
- Offset 0xC COUNT: read returns [15:0] op_count; any write clears it. op_count wraps 0xFFFF->0.
- FSM states: IDLE, WAIT, CAPTURE.
  - IDLE with FIFO non-empty: at the edge, load mul_a/mul_b/mul_control from the FIFO head, pop, cnt=LATENCY, go to WAIT.
  - WAIT: cnt decrements each edge; at cnt==1 go to CAPTURE.
  - CAPTURE: at the edge, result<=mul_p, res_valid<=1, op_count++, go to IDLE.
- Timing: mul_p is sampled LATENCY+1 edges after the operands change, and the operands are stable throughout.
- Latency: a CMD write sampled at edge E0 gives res_valid=1 after edge E0+LATENCY+2. Throughput is 1 op per LATENCY+2 cycles when the FIFO is kept non-empty.
- Capture while res_valid=1 and no RESULT read at that edge: overwrite, set res_lost sticky.
- Capture at the same edge as a RESULT read: the read returns the old value; res_valid ends at 1; res_lost is not set.
- Soft clear at the same edge as a CMD push: the clear wins and the FIFO ends empty.
- Reset mid-operation: immediate return to the reset state; no capture.

Test Plan:
- Reset, then read 0x0 -> 0x0000_0008 (empty=1); mul_a=mul_b=0, irq_o=0, wbs_ack_o=0.
- Write CMD 0x0000_0C0B (a=11, b=12), poll RESULT -> res_valid set exactly 4 cycles after the write edge (LATENCY=2). Model mul_p=a*b: read 0x0001_0084, next read 0x0000_0084, COUNT=1.
- Write 5 CMDs back-to-back with the FSM stalled on the first -> 5th dropped, ovf_err=1, count=3 after the first pop. Check the 4 results in order with no loss when read promptly.
- Two CMDs, RESULT never read -> second capture sets res_lost=1; RESULT = second product.
- irq_en=1, one CMD -> irq_o rises with res_valid and falls the cycle after the RESULT read ack. Soft clear during WAIT -> no capture, FSM IDLE, count unchanged.
- Drive wb_rst_n low mid-WAIT with 2 queued -> all state 0, FIFO empty, no further results. Also: access outside the window (adr 0x3000_0200) -> no ack.
